// File: rtl/fetch_seq.sv
// ============================================================================
//  Module      : fetch_seq
//  Description : MIPS fetch sequencer. Owns the PC, reads instruction memory
//                over req/ack and hands words to decode over valid/ready.
//                Applies branch/jump redirects, run-enable and halt.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module fetch_seq #(
    parameter int          ADDR_W   = 10,
    parameter int          DATA_W   = 32,
    parameter int unsigned RESET_PC = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic              halt_req,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_ack,
    input  logic [DATA_W-1:0] imem_rdata,
    output logic              instr_valid,
    output logic [DATA_W-1:0] instr,
    output logic [ADDR_W-1:0] instr_pc,
    input  logic              instr_ready,
    input  logic              redir_valid,
    input  logic              redir_is_jump,
    input  logic [15:0]       redir_off,
    input  logic [ADDR_W-1:0] redir_target,
    output logic [ADDR_W-1:0] pc_out,
    output logic              halted
);

    localparam logic [1:0] c_IDLE  = 2'd0;
    localparam logic [1:0] c_FETCH = 2'd1;
    localparam logic [1:0] c_ISSUE = 2'd2;
    localparam logic [1:0] c_HALT  = 2'd3;

    localparam logic [ADDR_W-1:0] c_RESET_PC = ADDR_W'(RESET_PC);
    localparam logic [ADDR_W-1:0] c_ONE      = {{(ADDR_W-1){1'b0}}, 1'b1};

    logic [1:0]        r_state;
    logic [ADDR_W-1:0] r_pc;
    logic [ADDR_W-1:0] r_last_pc;
    logic              r_pend;
    logic [ADDR_W-1:0] r_pend_tgt;

    logic [1:0]        w_state_nxt;
    logic [ADDR_W-1:0] w_pc_nxt;
    logic [ADDR_W-1:0] w_last_nxt;
    logic              w_pend_nxt;
    logic [ADDR_W-1:0] w_pend_tgt_nxt;
    logic              w_capture;
    logic              w_req_nxt;
    logic              w_valid_nxt;
    logic              w_ack;
    logic [ADDR_W-1:0] w_off;
    logic [ADDR_W-1:0] w_tgt;

    // An ack only counts against a request actually on the bus; stray acks are ignored.
    assign w_ack  = imem_ack & imem_req;
    assign w_off  = ADDR_W'($signed(redir_off));
    assign w_tgt  = redir_is_jump ? redir_target : (r_last_pc + c_ONE + w_off);
    assign pc_out = r_pc;

    always_comb begin
        w_state_nxt    = r_state;
        w_pc_nxt       = r_pc;
        w_last_nxt     = r_last_pc;
        w_pend_nxt     = r_pend;
        w_pend_tgt_nxt = r_pend_tgt;
        w_capture      = 1'b0;
        case (r_state)
            c_IDLE: begin
                if (redir_valid)
                    w_pc_nxt = w_tgt;
                else if (en && !halt_req)
                    w_state_nxt = c_FETCH;
            end
            c_FETCH: begin
                if (w_ack) begin
                    if (redir_valid || r_pend) begin
                        w_pc_nxt   = redir_valid ? w_tgt : r_pend_tgt;
                        w_pend_nxt = 1'b0;
                    end else begin
                        w_capture   = 1'b1;
                        w_pc_nxt    = r_pc + c_ONE;
                        w_state_nxt = c_ISSUE;
                    end
                end else if (redir_valid) begin
                    w_pend_nxt     = 1'b1;
                    w_pend_tgt_nxt = w_tgt;
                end
            end
            c_ISSUE: begin
                if (redir_valid) begin
                    w_pc_nxt    = w_tgt;
                    w_state_nxt = en ? c_FETCH : c_IDLE;
                end else if (instr_ready) begin
                    w_last_nxt  = instr_pc;
                    w_state_nxt = halt_req ? c_HALT : (en ? c_FETCH : c_IDLE);
                end
            end
            default: begin
                if (redir_valid)
                    w_pc_nxt = w_tgt;
                if (!halt_req)
                    w_state_nxt = en ? c_FETCH : c_IDLE;
            end
        endcase
        // A completed read always drops the request for a cycle, even when FETCH is re-entered.
        w_req_nxt   = (w_state_nxt == c_FETCH) && !((r_state == c_FETCH) && w_ack);
        w_valid_nxt = (w_state_nxt == c_ISSUE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= c_IDLE;
            r_pc        <= c_RESET_PC;
            r_last_pc   <= c_RESET_PC;
            r_pend      <= 1'b0;
            r_pend_tgt  <= '0;
            imem_req    <= 1'b0;
            imem_addr   <= '0;
            instr_valid <= 1'b0;
            instr       <= '0;
            instr_pc    <= '0;
            halted      <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_pc        <= w_pc_nxt;
            r_last_pc   <= w_last_nxt;
            r_pend      <= w_pend_nxt;
            r_pend_tgt  <= w_pend_tgt_nxt;
            imem_req    <= w_req_nxt;
            instr_valid <= w_valid_nxt;
            halted      <= (w_state_nxt == c_HALT);
            if (w_req_nxt && !imem_req)
                imem_addr <= w_pc_nxt;
            if (w_capture) begin
                instr    <= imem_rdata;
                instr_pc <= r_pc;
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_fetch_seq.sv
// ============================================================================
//  Module      : tb_fetch_seq
//  Description : Directed self-checking bench for fetch_seq.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_fetch_seq;

    logic        clk = 1'b0;
    logic        rst;
    logic        en, en_w, halt_req, instr_ready;
    logic        redir_valid, redir_is_jump;
    logic [15:0] redir_off;
    logic [9:0]  redir_target;
    logic        stray_ack;
    int          mem_delay;

    logic        imem_req, imem_ack, instr_valid, halted;
    logic [9:0]  imem_addr, instr_pc, pc_out;
    logic [31:0] imem_rdata, instr;

    logic        wr_req, wr_ack, wr_valid, wr_halted;
    logic [9:0]  wr_addr, wr_ipc, wr_pc;
    logic [31:0] wr_rdata, wr_instr;

    logic        mem_ack, wm_ack;
    int          mem_cnt;
    int          cyc;
    int          n_chk = 0;
    int          n_pass = 0;

    logic [9:0]  acc_pc[$];
    logic [31:0] acc_instr[$];
    int          acc_cyc[$];
    logic [9:0]  fetch_q[$];
    logic [9:0]  wfetch_q[$];
    int          wacc_cyc[$];

    always #5 clk = ~clk;

    assign imem_ack = mem_ack | stray_ack;
    assign wr_ack   = wm_ack;

    fetch_seq #(.ADDR_W(10), .DATA_W(32), .RESET_PC(0)) dut (
        .clk(clk), .rst(rst), .en(en), .halt_req(halt_req),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack),
        .imem_rdata(imem_rdata), .instr_valid(instr_valid), .instr(instr),
        .instr_pc(instr_pc), .instr_ready(instr_ready), .redir_valid(redir_valid),
        .redir_is_jump(redir_is_jump), .redir_off(redir_off),
        .redir_target(redir_target), .pc_out(pc_out), .halted(halted)
    );

    fetch_seq #(.ADDR_W(10), .DATA_W(32), .RESET_PC(1022)) dut_w (
        .clk(clk), .rst(rst), .en(en_w), .halt_req(1'b0),
        .imem_req(wr_req), .imem_addr(wr_addr), .imem_ack(wr_ack),
        .imem_rdata(wr_rdata), .instr_valid(wr_valid), .instr(wr_instr),
        .instr_pc(wr_ipc), .instr_ready(1'b1), .redir_valid(1'b0),
        .redir_is_jump(1'b0), .redir_off(16'h0000),
        .redir_target(10'h000), .pc_out(wr_pc), .halted(wr_halted)
    );

    // Memory model: ack arrives mem_delay+1 cycles after the request is seen; rdata = addr + 0x100.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_ack    <= 1'b0;
            mem_cnt    <= 0;
            imem_rdata <= '0;
        end else begin
            mem_ack <= 1'b0;
            if (imem_req && !mem_ack) begin
                if (mem_cnt == mem_delay) begin
                    mem_ack    <= 1'b1;
                    imem_rdata <= 32'(imem_addr) + 32'h100;
                    mem_cnt    <= 0;
                end else begin
                    mem_cnt <= mem_cnt + 1;
                end
            end else if (!imem_req) begin
                mem_cnt <= 0;
            end
        end
    end

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            wm_ack   <= 1'b0;
            wr_rdata <= '0;
        end else begin
            wm_ack <= wr_req && !wm_ack;
            if (wr_req && !wm_ack)
                wr_rdata <= 32'(wr_addr) + 32'h100;
        end
    end

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (!rst) begin
            if (instr_valid && instr_ready && !redir_valid) begin
                acc_pc.push_back(instr_pc);
                acc_instr.push_back(instr);
                acc_cyc.push_back(cyc);
            end
            if (imem_req && imem_ack)
                fetch_q.push_back(imem_addr);
            if (wr_req && wr_ack)
                wfetch_q.push_back(wr_addr);
            if (wr_valid)
                wacc_cyc.push_back(cyc);
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp)
            n_pass++;
        else
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_valid_pc(input logic [9:0] p, input string tag);
        int k = 0;
        while (!(instr_valid && instr_pc == p) && k < 40) begin
            tick();
            k++;
        end
        check(tag, 32'(instr_valid && instr_pc == p), 32'd1);
    endtask

    task automatic redirect(input logic jump, input logic [15:0] off, input logic [9:0] tgt);
        redir_valid   = 1'b1;
        redir_is_jump = jump;
        redir_off     = off;
        redir_target  = tgt;
    endtask

    initial begin
        cyc = 0;
        rst = 1'b1; en = 1'b0; en_w = 1'b0; halt_req = 1'b0; instr_ready = 1'b1;
        redir_valid = 1'b0; redir_is_jump = 1'b0; redir_off = '0; redir_target = '0;
        stray_ack = 1'b0; mem_delay = 0;
        tick(); tick();

        check("rst_req",    32'(imem_req),    32'd0);
        check("rst_addr",   32'(imem_addr),   32'd0);
        check("rst_valid",  32'(instr_valid), 32'd0);
        check("rst_instr",  instr,            32'd0);
        check("rst_ipc",    32'(instr_pc),    32'd0);
        check("rst_halted", 32'(halted),      32'd0);
        check("rst_pc",     32'(pc_out),      32'd0);
        check("rst_pc_w",   32'(wr_pc),       32'd1022);

        // Sequential fetch from reset, one instruction per three cycles
        rst = 1'b0; en = 1'b1; en_w = 1'b1;
        for (int k = 0; k < 60 && acc_pc.size() < 4; k++) tick();
        check("seq_count", 32'(acc_pc.size()), 32'd4);
        check("seq_pc_out", 32'(pc_out), 32'd4);
        for (int i = 0; i < 4; i++) begin
            check($sformatf("seq_addr%0d", i),  32'(fetch_q[i]), 32'(i));
            check($sformatf("seq_ipc%0d", i),   32'(acc_pc[i]),  32'(i));
            check($sformatf("seq_instr%0d", i), acc_instr[i],    32'h100 + 32'(i));
        end
        check("seq_rate", 32'(acc_cyc[3] - acc_cyc[2]), 32'd3);

        // Wrap-around of the PC instance that resets to 1022
        check("wrap_count", 32'(wfetch_q.size() >= 4), 32'd1);
        check("wrap_a0", 32'(wfetch_q[0]), 32'd1022);
        check("wrap_a1", 32'(wfetch_q[1]), 32'd1023);
        check("wrap_a2", 32'(wfetch_q[2]), 32'd0);
        check("wrap_a3", 32'(wfetch_q[3]), 32'd1);
        check("wrap_rate", 32'(wacc_cyc[3] - wacc_cyc[0]), 32'd9);
        en_w = 1'b0;

        en = 1'b0;
        repeat (8) tick();
        check("stop_pc", 32'(pc_out), 32'd5);
        check("stop_req", 32'(imem_req), 32'd0);

        // Branch -3 squashes the held instruction at 6
        en = 1'b1;
        wait_valid_pc(10'd5, "br_wait5");
        wait_valid_pc(10'd6, "br_wait6");
        redirect(1'b0, 16'hFFFD, 10'd0);
        instr_ready = 1'b0;
        tick();
        redir_valid = 1'b0; instr_ready = 1'b1;
        check("br_req", 32'(imem_req), 32'd1);
        check("br_addr", 32'(imem_addr), 32'd3);
        check("br_squash", 32'(instr_valid), 32'd0);
        check("br_last_acc", 32'(acc_pc[acc_pc.size()-1]), 32'd5);
        wait_valid_pc(10'd3, "br_wait3");
        check("br_instr3", instr, 32'h103);
        tick();
        check("br2_addr", 32'(imem_addr), 32'd4);
        // Branch +10 lands while the fetch of 4 is outstanding
        redirect(1'b0, 16'd10, 10'd0);
        tick();
        redir_valid = 1'b0;
        wait_valid_pc(10'd14, "br2_wait14");
        check("br2_instr", instr, 32'h10E);
        check("br2_last_acc", 32'(acc_pc[acc_pc.size()-1]), 32'd3);

        // Jump in IDLE, then a jump during a slow outstanding read
        en = 1'b0;
        repeat (4) tick();
        check("idle_req", 32'(imem_req), 32'd0);
        redirect(1'b1, 16'd0, 10'h040);
        tick();
        redir_valid = 1'b0;
        check("idle_redir_pc", 32'(pc_out), 32'h040);
        check("idle_stays", 32'(imem_req), 32'd0);
        mem_delay = 3; en = 1'b1;
        tick();
        check("jmp_addr_c1", 32'(imem_addr), 32'h040);
        tick();
        redirect(1'b1, 16'd0, 10'h200);
        tick();
        redir_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check($sformatf("jmp_req_c%0d", i+3),  32'(imem_req),    32'd1);
            check($sformatf("jmp_addr_c%0d", i+3), 32'(imem_addr),   32'h040);
            check($sformatf("jmp_valid_c%0d", i+3), 32'(instr_valid), 32'd0);
            tick();
        end
        check("jmp_gap_req", 32'(imem_req), 32'd0);
        check("jmp_gap_valid", 32'(instr_valid), 32'd0);
        tick();
        check("jmp_new_req", 32'(imem_req), 32'd1);
        check("jmp_new_addr", 32'(imem_addr), 32'h200);
        mem_delay = 0; instr_ready = 1'b0;

        // Backpressure then halt
        wait_valid_pc(10'h200, "bp_wait");
        check("bp_instr", instr, 32'h300);
        for (int i = 0; i < 5; i++) begin
            tick();
            check($sformatf("bp_instr%0d", i), instr, 32'h300);
            check($sformatf("bp_ipc%0d", i), 32'(instr_pc), 32'h200);
            check($sformatf("bp_req%0d", i), 32'(imem_req), 32'd0);
        end
        halt_req = 1'b1; instr_ready = 1'b1;
        tick();
        check("halt_on", 32'(halted), 32'd1);
        check("halt_pc", 32'(pc_out), 32'h201);
        check("halt_valid", 32'(instr_valid), 32'd0);
        tick(); tick();
        check("halt_hold", 32'(halted), 32'd1);
        check("halt_noreq", 32'(imem_req), 32'd0);
        halt_req = 1'b0;
        tick();
        check("resume_halted", 32'(halted), 32'd0);
        check("resume_req", 32'(imem_req), 32'd1);
        check("resume_addr", 32'(imem_addr), 32'h201);

        // Async reset mid-FETCH with a pending redirect
        mem_delay = 3;
        redirect(1'b1, 16'd0, 10'h055);
        tick();
        redir_valid = 1'b0;
        tick();
        #4 rst = 1'b1;
        #1;
        check("arst_req", 32'(imem_req), 32'd0);
        check("arst_pc", 32'(pc_out), 32'd0);
        check("arst_valid", 32'(instr_valid), 32'd0);
        en = 1'b0;
        tick();
        rst = 1'b0; stray_ack = 1'b1;
        tick();
        stray_ack = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check($sformatf("stray_valid%0d", i), 32'(instr_valid), 32'd0);
            check($sformatf("stray_req%0d", i), 32'(imem_req), 32'd0);
            tick();
        end
        mem_delay = 0; en = 1'b1;
        wait_valid_pc(10'd0, "post_rst_wait");
        check("post_rst_instr", instr, 32'h100);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

`default_nettype wire
